qspi_xfer_sequencer: RTL
========================

# qspi_xfer_sequencer

Transaction sequencer for the QSPI shift-register datapath. Accepts a one-shot request (command byte, optional 24-bit address, optional 32-bit write word, each phase with its own lane width) and drives the shift register's load, shift, data and lane-select controls. It also generates SCLK and CS_n for SPI mode 0. It sits between the AHB-facing config/FIFO logic and the shift register.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles; legal range ≥2.
- `clk` in 1: system clock (HCLK).
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `abort` in 1: terminate current transfer.
- `cmd` in 8: command byte.
- `addr` in 24: address.
- `wdata` in 32: write data word.
- `has_addr` in 1: include the address phase.
- `has_data` in 1: include the data phase.
- `cmd_lanes`, `addr_lanes`, `data_lanes` in 2 each: lane code per phase. 00=1, 01=2, 10=4, 11 treated as 1.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `sr_load` out 1: shift-register load strobe.
- `sr_data` out 32: shift-register load value.
- `shift_en` out 1: shift-register shift strobe.
- `use_1_io_lines`, `use_2_io_lines`, `use_4_io_lines` out 1 each: one-hot lane select, all 0 when idle.
- `sclk` out 1: QSPI serial clock, idle low.
- `cs_n` out 1: chip select, active low.

## Operation
- All outputs are registered.
- Reset values: `cs_n`=1; all other outputs 0.
- States: IDLE, CMD, ADDR, DATA, HOLD.
- IDLE→CMD on `start`=1 and `abort`=0. At that edge E0:
  - `cs_n`←0, `busy`←1.
  - `sr_load`←1 for one cycle, with `sr_data`←{cmd,24'h0}.
  - Lane select ← `cmd_lanes`.
  - `cmd`, `addr`, `wdata` and all lane/enable inputs are captured.
- Phase load values:
  - ADDR: `sr_data`={addr,8'h0}.
  - DATA: `sr_data`=wdata.
  - Data is MSB-first, left-justified.
- Beats per phase = phase_bits / lanes:
  - CMD: 8 / 4 / 2 beats for 1 / 2 / 4 lanes.
  - ADDR: 24 / 12 / 6.
  - DATA: 32 / 16 / 8.
- A beat is one SCLK period: low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles. Data changes on the falling edge and is sampled by the flash on the rising edge.
- At each falling-edge clk edge:
  - If beats remain in the phase: `shift_en`=1 for one cycle.
  - Else, if a next enabled phase exists: `sr_load`=1 with the next phase's data and lane select updated at the same edge. No `shift_en`.
  - Else: go to HOLD. No `shift_en`, no `sr_load`.
- Phase order is CMD→ADDR (if `has_addr`)→DATA (if `has_data`). Skipped phases generate no beats.
- HOLD lasts `CLK_DIV` cycles with `sclk`=0, then one edge does all of: `cs_n`←1, `busy`←0, `done`←1, lane selects←0, state←IDLE.
- `start` while `busy`: ignored, no effect.
- `abort`=1 in any non-IDLE state forces the following at the next edge:
  - State←IDLE.
  - `cs_n`←1, `sclk`←0, `busy`←0.
  - `sr_load`, `shift_en` and lane selects ←0.
  - No `done` pulse.
- `abort` and `start` together in IDLE: abort wins, no transfer starts.
- `rst` mid-transfer: all outputs return to their reset values immediately (asynchronous). No `done` pulse.

## Timing
- E0 is the edge that accepts `start`; N is the total beats across all enabled phases.
- `sclk` rises at edge E0+`CLK_DIV`+2k·`CLK_DIV` and falls at E0+2(k+1)·`CLK_DIV`, for k=0..N-1.
- Shift register outputs settle one cycle after `sr_load` or `shift_en`. `CLK_DIV`≥2 guarantees at least one cycle of setup before each rising edge.
- `done` asserts at edge E0+2N·`CLK_DIV`+`CLK_DIV`. `busy` is high from E0 to that edge, exclusive.
- Number of `shift_en` pulses per phase = beats−1. One `sr_load` per enabled phase.
- Back-to-back transfers: `start` may be accepted in the cycle after `done` (IDLE). `cs_n` is then high for at least one cycle.

## Test plan
- **Command only, 1-lane:** `CLK_DIV`=2, `cmd`=8'h9F, no addr/data → 8 SCLK pulses; 7 `shift_en`; 1 `sr_load` with `sr_data`=32'h9F000000; `done` at E0+34; `cs_n` low E0..E0+34.
- **Full quad transfer:** `cmd`=8'hEB, `addr`=24'h123456, `wdata`=32'hDEADBEEF, all lanes=10 → 16 beats (2+6+8); `sr_data` sequence EB000000, 12345600, DEADBEEF; `use_4_io_lines`=1 throughout; `done` at E0+66.
- **Mixed 1-1-4 widths:** lanes 00/00/10 → 40 beats; lane select switches 1→4 at the load edge of DATA; `done` at E0+162; `shift_en` counts 7/23/7.
- **Abort:** assert `abort` during the ADDR phase → next edge `cs_n`=1, `sclk`=0, `busy`=0, no `done`. A new `start` the following cycle is accepted normally.
- **Start ignored while busy, then reset:** pulse `start` mid-DATA → no effect. Assert `rst` mid-transfer → all outputs at reset values immediately; after release, IDLE with lane selects 0.
- **Illegal lane code:** `cmd_lanes`=11 behaves exactly as 00 (8 beats, `use_1_io_lines`=1).

Source files
------------

// File: rtl/qspi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qspi_xfer_sequencer
// Description : Sequences CMD / ADDR / DATA phases of a QSPI transfer, driving
//               shift-register load/shift/lane controls plus SCLK and CS_n.
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_xfer_sequencer #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  cmd,
    input  logic [23:0] addr,
    input  logic [31:0] wdata,
    input  logic        has_addr,
    input  logic        has_data,
    input  logic [1:0]  cmd_lanes,
    input  logic [1:0]  addr_lanes,
    input  logic [1:0]  data_lanes,
    output logic        busy,
    output logic        done,
    output logic        sr_load,
    output logic [31:0] sr_data,
    output logic        shift_en,
    output logic        use_1_io_lines,
    output logic        use_2_io_lines,
    output logic        use_4_io_lines,
    output logic        sclk,
    output logic        cs_n
);

    localparam int c_CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_RISE = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_FALL = c_CNT_W'(2 * CLK_DIV - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_CMD  = 3'd1;
    localparam logic [2:0] c_ADDR = 3'd2;
    localparam logic [2:0] c_DATA = 3'd3;
    localparam logic [2:0] c_HOLD = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [5:0]         r_beats_left;
    logic [23:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_has_addr;
    logic               r_has_data;
    logic [1:0]         r_addr_lanes;
    logic [1:0]         r_data_lanes;

    // Beats in a phase minus one; code 11 falls back to single lane.
    function automatic logic [5:0] f_last_beat(input logic [5:0] bits, input logic [1:0] code);
        case (code)
            2'b01:   return (bits >> 1) - 6'd1;
            2'b10:   return (bits >> 2) - 6'd1;
            default: return bits - 6'd1;
        endcase
    endfunction

    // Returns {use_4, use_2, use_1}.
    function automatic logic [2:0] f_lane_sel(input logic [1:0] code);
        case (code)
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_cnt          <= '0;
            r_beats_left   <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_has_addr     <= 1'b0;
            r_has_data     <= 1'b0;
            r_addr_lanes   <= 2'b00;
            r_data_lanes   <= 2'b00;
            busy           <= 1'b0;
            done           <= 1'b0;
            sr_load        <= 1'b0;
            sr_data        <= '0;
            shift_en       <= 1'b0;
            use_1_io_lines <= 1'b0;
            use_2_io_lines <= 1'b0;
            use_4_io_lines <= 1'b0;
            sclk           <= 1'b0;
            cs_n           <= 1'b1;
        end else begin
            sr_load  <= 1'b0;
            shift_en <= 1'b0;
            done     <= 1'b0;
            if (r_state != c_IDLE && abort) begin
                r_state <= c_IDLE;
                r_cnt   <= '0;
                cs_n    <= 1'b1;
                sclk    <= 1'b0;
                busy    <= 1'b0;
                {use_4_io_lines, use_2_io_lines, use_1_io_lines} <= 3'b000;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (start && !abort) begin
                            r_state      <= c_CMD;
                            r_cnt        <= '0;
                            r_beats_left <= f_last_beat(6'd8, cmd_lanes);
                            r_addr       <= addr;
                            r_wdata      <= wdata;
                            r_has_addr   <= has_addr;
                            r_has_data   <= has_data;
                            r_addr_lanes <= addr_lanes;
                            r_data_lanes <= data_lanes;
                            cs_n         <= 1'b0;
                            busy         <= 1'b1;
                            sr_load      <= 1'b1;
                            sr_data      <= {cmd, 24'h0};
                            {use_4_io_lines, use_2_io_lines, use_1_io_lines} <= f_lane_sel(cmd_lanes);
                        end
                    end
                    c_CMD, c_ADDR, c_DATA: begin
                        if (r_cnt == c_RISE) begin
                            sclk  <= 1'b1;
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end else if (r_cnt == c_FALL) begin
                            // Falling edge: advance within the phase, move to the next one, or finish.
                            sclk  <= 1'b0;
                            r_cnt <= '0;
                            if (r_beats_left != 6'd0) begin
                                shift_en     <= 1'b1;
                                r_beats_left <= r_beats_left - 6'd1;
                            end else if (r_state == c_CMD && r_has_addr) begin
                                r_state      <= c_ADDR;
                                sr_load      <= 1'b1;
                                sr_data      <= {r_addr, 8'h0};
                                r_beats_left <= f_last_beat(6'd24, r_addr_lanes);
                                {use_4_io_lines, use_2_io_lines, use_1_io_lines} <= f_lane_sel(r_addr_lanes);
                            end else if (r_state != c_DATA && r_has_data) begin
                                r_state      <= c_DATA;
                                sr_load      <= 1'b1;
                                sr_data      <= r_wdata;
                                r_beats_left <= f_last_beat(6'd32, r_data_lanes);
                                {use_4_io_lines, use_2_io_lines, use_1_io_lines} <= f_lane_sel(r_data_lanes);
                            end else begin
                                r_state <= c_HOLD;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    c_HOLD: begin
                        if (r_cnt == c_RISE) begin
                            r_state <= c_IDLE;
                            r_cnt   <= '0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            cs_n    <= 1'b1;
                            {use_4_io_lines, use_2_io_lines, use_1_io_lines} <= 3'b000;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
